// File: rtl/riscv_fetch_pkg.sv
// Shared constants, state encoding and queue entry layout for the fetch unit.
package riscv_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam int          FIFO_DEPTH       = 2;
    localparam logic [31:0] HALT_WORD        = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift queue of {pc, inst}; slot 0 is always the head, so the head is read straight from a register.
module fetch_fifo
    import riscv_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [63:0] i_push_data,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic [63:0] o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [63:0]   r_entry [FIFO_DEPTH];
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full  = (r_count == CW'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_entry[0];

    // A push into a full queue is only legal when the head leaves on the same edge.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (i_flush) begin
            r_count <= '0;
        end else if (w_pop && w_push) begin
            if (r_count == CW'(1)) begin
                r_entry[0] <= i_push_data;
            end else begin
                r_entry[0] <= r_entry[1];
                r_entry[1] <= i_push_data;
            end
        end else if (w_pop) begin
            r_entry[0] <= r_entry[1];
            r_count    <= r_count - CW'(1);
        end else if (w_push) begin
            r_entry[r_count[0]] <= i_push_data;
            r_count             <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Sequential instruction fetch: PC/state control feeding a two-entry queue toward decode, with redirect and halt-on-zero.
module inst_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter bit          HALT_ON_ZERO = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        halted
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    fetch_entry_t w_head;
    fetch_entry_t w_newEntry;
    logic         w_full;
    logic         w_empty;
    logic         w_deq;
    logic         w_slotFree;
    logic         w_zeroWord;
    logic         w_fetchTry;
    logic         w_enq;
    logic         w_haltNow;

    assign imem_addr = r_pc >> 2;
    assign out_valid = !w_empty;
    assign out_inst  = w_head.inst;
    assign out_pc    = w_head.pc;
    assign halted    = (r_state == ST_HALT);

    // A redirect voids any handshake, so the head stays put while the queue is flushed.
    assign w_deq      = out_valid && out_ready && !redirect_valid;
    assign w_slotFree = !w_full || w_deq;
    assign w_zeroWord = HALT_ON_ZERO && (imem_data == HALT_WORD);
    assign w_fetchTry = (r_state == ST_RUN) && !redirect_valid && w_slotFree;
    assign w_enq      = w_fetchTry && !w_zeroWord;
    assign w_haltNow  = w_fetchTry && w_zeroWord;

    assign w_newEntry.pc   = r_pc;
    assign w_newEntry.inst = imem_data;

    fetch_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_enq),
        .i_push_data (w_newEntry),
        .i_pop       (w_deq),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc & ~32'h0000_0003;
            r_state <= ST_RUN;
        end else if (w_enq) begin
            r_pc <= r_pc + PC_STEP;
        end else if (w_haltNow) begin
            r_state <= ST_HALT;
        end
    end

endmodule
